// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl
// Front-end controller for the egg timer: samples the keys, runs the
// set/start/pause/alarm mode machine, keeps the BCD mm:ss countdown and
// generates the once-per-second countdown tick while running.
module egg_timer_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        clkIn,
    input  logic        reset_btn,
    input  logic        key_set,
    input  logic        key_start,
    input  logic [7:0]  sw,
    output logic [2:0]  state,
    output logic [15:0] timer,
    output logic        tick,
    output logic        alarm
);

    // Prescaler width; TICK_DIV >= 2 keeps this at least one bit.
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_SET_SEC = 3'b001,
        ST_SET_MIN = 3'b010,
        ST_READY   = 3'b011,
        ST_PAUSE   = 3'b100,
        ST_RUN     = 3'b101,
        ST_DONE    = 3'b110
    } state_t;

    // Limit a two-digit BCD entry to a valid minute/second value (max 59).
    function automatic logic [7:0] clamp_bcd(input logic [7:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        if (value[7:4] > 4'd5) begin
            tens = 4'd5;
        end else begin
            tens = value[7:4];
        end
        if (value[3:0] > 4'd9) begin
            ones = 4'd9;
        end else begin
            ones = value[3:0];
        end
        return {tens, ones};
    endfunction

    // One-second BCD decrement of mm:ss with borrow ripple across digits.
    function automatic logic [15:0] bcd_dec(input logic [15:0] value);
        logic [3:0] sec_ones;
        logic [3:0] sec_tens;
        logic [3:0] min_ones;
        logic [3:0] min_tens;
        logic       borrow;
        sec_ones = value[3:0];
        sec_tens = value[7:4];
        min_ones = value[11:8];
        min_tens = value[15:12];
        if (sec_ones == 4'd0) begin
            sec_ones = 4'd9;
            borrow   = 1'b1;
        end else begin
            sec_ones = sec_ones - 4'd1;
            borrow   = 1'b0;
        end
        if (borrow) begin
            if (sec_tens == 4'd0) begin
                sec_tens = 4'd5;
                borrow   = 1'b1;
            end else begin
                sec_tens = sec_tens - 4'd1;
                borrow   = 1'b0;
            end
        end else begin
            borrow = 1'b0;
        end
        if (borrow) begin
            if (min_ones == 4'd0) begin
                min_ones = 4'd9;
                borrow   = 1'b1;
            end else begin
                min_ones = min_ones - 4'd1;
                borrow   = 1'b0;
            end
        end else begin
            borrow = 1'b0;
        end
        if (borrow) begin
            min_tens = min_tens - 4'd1;
        end else begin
            min_tens = value[15:12];
        end
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Key synchronizer and edge registers (idle level is high).
    logic set_sync1_r;
    logic set_sync2_r;
    logic set_prev_r;
    logic start_sync1_r;
    logic start_sync2_r;
    logic start_prev_r;

    // Press pulses derived from the synchronized levels.
    logic set_press_s;
    logic start_press_s;
    logic start_eff_s;
    logic any_press_s;

    // Mode machine, countdown and prescaler state.
    state_t           state_r;
    state_t           state_next_s;
    logic [15:0]      timer_r;
    logic [15:0]      timer_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             tick_r;
    logic             tick_next_s;
    logic             alarm_r;
    logic             alarm_next_s;
    logic             tick_due_s;
    logic             expire_s;

    // Bring both active-low keys into the clock domain and keep the previous level.
    always_ff @(posedge clkIn or negedge reset_btn) begin
        if (!reset_btn) begin
            set_sync1_r   <= 1'b1;
            set_sync2_r   <= 1'b1;
            set_prev_r    <= 1'b1;
            start_sync1_r <= 1'b1;
            start_sync2_r <= 1'b1;
            start_prev_r  <= 1'b1;
        end else begin
            set_sync1_r   <= key_set;
            set_sync2_r   <= set_sync1_r;
            set_prev_r    <= set_sync2_r;
            start_sync1_r <= key_start;
            start_sync2_r <= start_sync1_r;
            start_prev_r  <= start_sync2_r;
        end
    end

    // A press is a high-to-low step of the synchronized level; set wins over start.
    assign set_press_s   = set_prev_r & ~set_sync2_r;
    assign start_press_s = start_prev_r & ~start_sync2_r;
    assign start_eff_s   = start_press_s & ~set_press_s;
    assign any_press_s   = set_press_s | start_press_s;

    // The registered tick marks the last cycle of a second; the countdown acts on its closing edge.
    assign tick_due_s = (state_r == ST_RUN) && tick_r;
    assign expire_s   = tick_due_s && (timer_r == 16'h0001);

    // Mode transitions driven by key presses and countdown expiry.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (set_press_s) begin
                    state_next_s = ST_SET_SEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SET_SEC: begin
                if (set_press_s) begin
                    state_next_s = ST_SET_MIN;
                end else begin
                    state_next_s = ST_SET_SEC;
                end
            end
            ST_SET_MIN: begin
                if (set_press_s) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_SET_MIN;
                end
            end
            ST_READY: begin
                if (set_press_s) begin
                    state_next_s = ST_IDLE;
                end else if (start_eff_s && (timer_r != 16'h0000)) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_READY;
                end
            end
            ST_RUN: begin
                if (expire_s) begin
                    state_next_s = ST_DONE;
                end else if (start_eff_s) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (set_press_s) begin
                    state_next_s = ST_IDLE;
                end else if (start_eff_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (any_press_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Timer contents follow the mode being entered; the decrement follows the running tick.
    always_comb begin
        timer_next_s = timer_r;
        case (state_next_s)
            ST_IDLE: begin
                timer_next_s = 16'h0000;
            end
            ST_SET_SEC: begin
                timer_next_s = {timer_r[15:8], clamp_bcd(sw)};
            end
            ST_SET_MIN: begin
                timer_next_s = {clamp_bcd(sw), timer_r[7:0]};
            end
            ST_DONE: begin
                timer_next_s = 16'h0000;
            end
            ST_READY, ST_PAUSE, ST_RUN: begin
                if (tick_due_s) begin
                    timer_next_s = bcd_dec(timer_r);
                end else begin
                    timer_next_s = timer_r;
                end
            end
            default: begin
                timer_next_s = 16'h0000;
            end
        endcase
    end

    // Prescaler runs only while staying in RUN; each entry into RUN restarts a full second.
    always_comb begin
        cnt_next_s = CNT_ZERO;
        if (state_next_s == ST_RUN) begin
            if (state_r != ST_RUN) begin
                cnt_next_s = CNT_ZERO;
            end else if (cnt_r == CNT_MAX) begin
                cnt_next_s = CNT_ZERO;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else begin
            cnt_next_s = CNT_ZERO;
        end
        tick_next_s  = (state_next_s == ST_RUN) && (cnt_next_s == CNT_MAX);
        alarm_next_s = (state_next_s == ST_DONE);
    end

    // Mode machine and all output registers.
    always_ff @(posedge clkIn or negedge reset_btn) begin
        if (!reset_btn) begin
            state_r <= ST_IDLE;
            timer_r <= 16'h0000;
            cnt_r   <= CNT_ZERO;
            tick_r  <= 1'b0;
            alarm_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            timer_r <= timer_next_s;
            cnt_r   <= cnt_next_s;
            tick_r  <= tick_next_s;
            alarm_r <= alarm_next_s;
        end
    end

    assign state = state_r;
    assign timer = timer_r;
    assign tick  = tick_r;
    assign alarm = alarm_r;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Scoreboard bench for egg_timer_ctrl: the stimulus pushes every expected
// output change (with the clock edge it should occur on) into a queue and a
// separate monitor pops and compares each time the outputs change.
module tb_egg_timer_ctrl;

    localparam int TICK_DIV = 4;

    logic        clkIn = 1'b0;
    logic        reset_btn;
    logic        key_set;
    logic        key_start;
    logic [7:0]  sw;
    logic [2:0]  state;
    logic [15:0] timer;
    logic        tick;
    logic        alarm;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int          cy;
        logic [2:0]  st;
        logic [15:0] tm;
        logic        tk;
        logic        al;
    } ev_t;

    ev_t exp_q[$];

    egg_timer_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clkIn     (clkIn),
        .reset_btn (reset_btn),
        .key_set   (key_set),
        .key_start (key_start),
        .sw        (sw),
        .state     (state),
        .timer     (timer),
        .tick      (tick),
        .alarm     (alarm)
    );

    always #5 clkIn = ~clkIn;

    always @(posedge clkIn) cyc <= cyc + 1;

    task automatic expect_ev(input int cy, input logic [2:0] st, input logic [15:0] tm,
                             input logic tk, input logic al);
        ev_t e;
        e.cy = cy;
        e.st = st;
        e.tm = tm;
        e.tk = tk;
        e.al = al;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    // Hold the chosen keys low for 4 cycles, then idle 4 cycles so the next press is clean.
    task automatic press(input logic do_set, input logic do_start);
        key_set   = ~do_set;
        key_start = ~do_start;
        cycles(4);
        key_set   = 1'b1;
        key_start = 1'b1;
        cycles(4);
    endtask

    // IDLE -> SET_SEC -> SET_MIN -> READY; cs/cm are the hand-clamped values of sec/mn.
    task automatic goto_ready(input logic [7:0] sec, input logic [7:0] mn,
                              input logic [7:0] cs, input logic [7:0] cm);
        sw = sec;
        expect_ev(cyc + 3, 3'd1, {8'h00, cs}, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        expect_ev(cyc + 3, 3'd2, {cs, cs}, 1'b0, 1'b0);
        press(1'b1, 1'b0);
        if (cm != cs) expect_ev(cyc + 1, 3'd2, {cm, cs}, 1'b0, 1'b0);
        sw = mn;
        cycles(2);
        expect_ev(cyc + 3, 3'd3, {cm, cs}, 1'b0, 1'b0);
        press(1'b1, 1'b0);
    endtask

    // Monitor: every change of the output bundle consumes one expected event.
    initial begin
        logic [20:0] prev_v;
        logic [20:0] cur_v;
        bit          first;
        ev_t         e;
        first = 1'b1;
        prev_v = '0;
        forever begin
            @(negedge clkIn);
            cur_v = {state, timer, tick, alarm};
            if (first || (cur_v !== prev_v)) begin
                first  = 1'b0;
                prev_v = cur_v;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change cycle=%0d got state=%0h timer=%04h tick=%0b alarm=%0b, required no change",
                             cyc, state, timer, tick, alarm);
                end else begin
                    e = exp_q.pop_front();
                    if ((state !== e.st) || (timer !== e.tm) || (tick !== e.tk) ||
                        (alarm !== e.al) || ((e.cy >= 0) && (e.cy != cyc))) begin
                        failures++;
                        $display("FAIL event got cycle=%0d state=%0h timer=%04h tick=%0b alarm=%0b required cycle=%0d state=%0h timer=%04h tick=%0b alarm=%0b",
                                 cyc, state, timer, tick, alarm, e.cy, e.st, e.tm, e.tk, e.al);
                    end
                end
            end
        end
    end

    initial begin
        int e0;
        int r;
        reset_btn = 1'b1;
        key_set   = 1'b1;
        key_start = 1'b1;
        sw        = 8'h00;
        expect_ev(-1, 3'd0, 16'h0000, 1'b0, 1'b0);
        #1 reset_btn = 1'b0;
        cycles(3);
        reset_btn = 1'b1;
        cycles(2);

        // Entry with sw=30, then minutes clamp AF -> 59; READY holds while sw changes.
        goto_ready(8'h30, 8'hAF, 8'h30, 8'h59);
        sw = 8'h12;
        cycles(4);
        // Simultaneous set + start in READY counts as set only.
        expect_ev(cyc + 3, 3'd0, 16'h0000, 1'b0, 1'b0);
        press(1'b1, 1'b1);

        // Seconds clamp 7C -> 59, then set in READY returns to IDLE.
        goto_ready(8'h7C, 8'h01, 8'h59, 8'h01);
        expect_ev(cyc + 3, 3'd0, 16'h0000, 1'b0, 1'b0);
        press(1'b1, 1'b0);

        // Zero timer: start in READY is ignored.
        goto_ready(8'h00, 8'h00, 8'h00, 8'h00);
        press(1'b0, 1'b1);
        cycles(2);
        expect_ev(cyc + 3, 3'd0, 16'h0000, 1'b0, 1'b0);
        press(1'b1, 1'b0);

        // Countdown from 01:00, pause two cycles into a second, resume, async reset.
        goto_ready(8'h00, 8'h01, 8'h00, 8'h01);
        e0 = cyc + 3;
        expect_ev(e0,      3'd5, 16'h0100, 1'b0, 1'b0);
        expect_ev(e0 + 3,  3'd5, 16'h0100, 1'b1, 1'b0);
        expect_ev(e0 + 4,  3'd5, 16'h0059, 1'b0, 1'b0);
        expect_ev(e0 + 7,  3'd5, 16'h0059, 1'b1, 1'b0);
        expect_ev(e0 + 8,  3'd5, 16'h0058, 1'b0, 1'b0);
        expect_ev(e0 + 11, 3'd5, 16'h0058, 1'b1, 1'b0);
        expect_ev(e0 + 12, 3'd5, 16'h0057, 1'b0, 1'b0);
        press(1'b0, 1'b1);
        cycles(e0 + 11 - cyc);
        expect_ev(e0 + 14, 3'd4, 16'h0057, 1'b0, 1'b0);
        press(1'b0, 1'b1);
        cycles(3);
        r = cyc + 3;
        expect_ev(r,     3'd5, 16'h0057, 1'b0, 1'b0);
        expect_ev(r + 3, 3'd5, 16'h0057, 1'b1, 1'b0);
        expect_ev(r + 4, 3'd5, 16'h0056, 1'b0, 1'b0);
        press(1'b0, 1'b1);
        @(posedge clkIn);
        #2;
        expect_ev(cyc, 3'd0, 16'h0000, 1'b0, 1'b0);
        reset_btn = 1'b0;
        cycles(3);
        reset_btn = 1'b1;
        cycles(2);

        // Expiry from 00:02, then start press clears the alarm.
        goto_ready(8'h02, 8'h00, 8'h02, 8'h00);
        e0 = cyc + 3;
        expect_ev(e0,     3'd5, 16'h0002, 1'b0, 1'b0);
        expect_ev(e0 + 3, 3'd5, 16'h0002, 1'b1, 1'b0);
        expect_ev(e0 + 4, 3'd5, 16'h0001, 1'b0, 1'b0);
        expect_ev(e0 + 7, 3'd5, 16'h0001, 1'b1, 1'b0);
        expect_ev(e0 + 8, 3'd6, 16'h0000, 1'b0, 1'b1);
        press(1'b0, 1'b1);
        cycles(5);
        expect_ev(cyc + 3, 3'd0, 16'h0000, 1'b0, 1'b0);
        press(1'b0, 1'b1);

        cycles(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
